// File: rtl/subtrator_serial_n.sv
// subtrator_serial_n: multi-cycle diff = a - b - bin using BITS_PER_CYCLE chained full-subtractor cells, LSB first.
// Define SUBTRATOR_OVERFLOW_EN to build the signed overflow flag; otherwise ovf is tied low.
module subtrator_serial_n #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // state  | meaning
  // S_IDLE | waiting for start, ready=1
  // S_RUN  | consuming BITS_PER_CYCLE operand bits per edge, busy=1
  // S_DONE | one-cycle done pulse, ready=1 so a back-to-back start is accepted

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_check
    $error("subtrator_serial_n: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          a_q, b_q, r_q, diff_q;
  logic                      br_q, bout_q;
  logic [CW-1:0]             cnt_q;
  logic [BITS_PER_CYCLE-1:0] chunk_d;
  logic                      chain_br;
  logic [WIDTH-1:0]          r_next;
  logic                      accept;
  logic                      last_step;

  always_comb begin
    chain_br = br_q;
    chunk_d  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_d[i] = a_q[i] ^ b_q[i] ^ chain_br;
      chain_br   = (~a_q[i] & b_q[i]) | (~a_q[i] & chain_br) | (b_q[i] & chain_br);
    end
    // result chunks enter from the MSB side so the first chunk ends up at bit 0
    r_next = r_q >> BITS_PER_CYCLE;
    r_next[WIDTH-1 -: BITS_PER_CYCLE] = chunk_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = ready & start;
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      r_q   <= '0;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      a_q   <= a_q >> BITS_PER_CYCLE;
      b_q   <= b_q >> BITS_PER_CYCLE;
      r_q   <= r_next;
      br_q  <= chain_br;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        diff_q <= r_next;
        bout_q <= chain_br;
      end
    end
  end

`ifdef SUBTRATOR_OVERFLOW_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (last_step) begin
      ovf_q <= (a_msb_q != b_msb_q) && (r_next[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_subtrator_serial_n.sv
// Bench for subtrator_serial_n: four instances (BITS_PER_CYCLE 1,2,4,8) checked through per-instance scoreboards.
module tb_subtrator_serial_n;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [4];
  logic [7:0] a_s = '0, b_s = '0;
  logic       bin_s = 1'b0;
  logic       ready_w [4], busy_w [4], done_w [4], bout_w [4], ovf_w [4];
  logic [7:0] diff_w [4];

  exp_t sb_q [4][$];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    subtrator_serial_n #(.WIDTH(8), .BITS_PER_CYCLE(1 << k)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[k]),
      .a(a_s), .b(b_s), .bin(bin_s),
      .ready(ready_w[k]), .busy(busy_w[k]), .done(done_w[k]),
      .diff(diff_w[k]), .bout(bout_w[k]), .ovf(ovf_w[k])
    );
  end

  function automatic logic ov_en(input logic ov);
`ifdef SUBTRATOR_OVERFLOW_EN
    return ov;
`else
    return 1'b0 & ov;
`endif
  endfunction

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    logic [8:0] wide;
    exp_t       e;
    wide = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    e.d  = wide[7:0];
    e.bo = wide[8];
    e.ov = ov_en((ma[7] != mb[7]) && (wide[7] != ma[7]));
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s [bpc=%0d]: got %0h, expected %0h", nm, 1 << k, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for DUT, got no event, expected one", nm);
  endtask

  // scoreboard consumer: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (done_w[k]) begin
          if (sb_q[k].size() == 0) begin
            chk("unexpected_done", k, 32'd1, 32'd0);
          end else begin
            e = sb_q[k].pop_front();
            chk("result", k, {22'd0, diff_w[k], bout_w[k], ovf_w[k]}, {22'd0, e});
          end
        end
      end
    end
  end

  function automatic logic all_ready(input logic [3:0] mask);
    logic r = 1'b1;
    for (int k = 0; k < 4; k++) if (mask[k] && !ready_w[k]) r = 1'b0;
    return r;
  endfunction

  function automatic logic all_drained(input logic [3:0] mask);
    logic r = 1'b1;
    for (int k = 0; k < 4; k++) if (mask[k] && sb_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  // returns #1 after the accepting edge
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input exp_t e, input logic [3:0] mask);
    int t = 0;
    @(negedge clk);
    while (!all_ready(mask) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("ready_wait");
    a_s = ia; b_s = ib; bin_s = ibin;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        start_v[k] = 1'b1;
        sb_q[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
  endtask

  task automatic wait_drain(input logic [3:0] mask);
    int t = 0;
    while (!all_drained(mask) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("drain_wait");
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    int   lat [4];
    int   busy_n;
    int   t;
    logic [7:0] ra, rb;
    logic       rbin;

    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5]  = '{8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0};
    vecs[6]  = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[11] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{8'hAA, 8'h11, 1'b0, 8'h99, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) start_v[k] = 1'b0;

    // reset values
    #12;
    for (int k = 0; k < 4; k++)
      chk("reset_state", k, {20'd0, ready_w[k], busy_w[k], done_w[k], diff_w[k], bout_w[k], ovf_w[k]},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // latency and busy length, all widths in parallel
    run_op(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 4'hF);
    for (int k = 0; k < 4; k++) lat[k] = -1;
    busy_n = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (busy_w[0]) busy_n++;
      for (int k = 0; k < 4; k++) if (done_w[k] && lat[k] < 0) lat[k] = c;
      if (c < 20) @(posedge clk);
    end
    for (int k = 0; k < 4; k++) chk("latency_edges", k, lat[k], 8 >> k);
    chk("busy_cycles", 0, busy_n, 8);
    wait_drain(4'hF);

    // back-to-back launch in the DONE cycle
    run_op(8'h03, 8'h05, 1'b0, '{8'hFE, 1'b1, 1'b0}, 4'h1);
    t = 0;
    @(negedge clk);
    while (!done_w[0] && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) timeout("b2b_done_wait");
    a_s = 8'h00; b_s = 8'h00; bin_s = 1'b1;
    start_v[0] = 1'b1;
    sb_q[0].push_back('{8'hFF, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    wait_drain(4'h1);

    // start during RUN must be ignored
    run_op(8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, ov_en(1'b1)}, 4'h1);
    @(negedge clk);
    @(negedge clk);
    a_s = 8'hAA; b_s = 8'h11; bin_s = 1'b1;
    start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    wait_drain(4'h1);
    repeat (12) @(negedge clk);

    // async reset on the 4th RUN cycle discards the operation
    run_op(8'h55, 8'h22, 1'b0, '{8'h33, 1'b0, 1'b0}, 4'h1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", 0, {20'd0, ready_w[0], busy_w[0], done_w[0], diff_w[0], bout_w[0], ovf_w[0]},
        {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    sb_q[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, '{8'h0F, 1'b0, 1'b0}, 4'hF);
    wait_drain(4'hF);

    // vector table on all four widths
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, '{vecs[i].d, vecs[i].bo, ov_en(vecs[i].ov)}, 4'hF);
      wait_drain(4'hF);
    end

    // random operations against the reference model
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, model(ra, rb, rbin), 4'hF);
      wait_drain(4'hF);
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("scoreboard_empty", k, sb_q[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
